snake_dir_input: RTL and testbench
==================================

# snake_dir_input

Upstream input stage for `game_logic`. It synchronizes and debounces the four raw direction buttons and queues up to two pending turns, rejecting reversals and repeats. It also generates `update_clk` from `vga_clk` and applies one queued turn per update period, so `direction` is always stable when `game_logic` samples it on the rising edge of `update_clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable `vga_clk` cycles needed to accept a button level (10 ms at 25 MHz).
- `UPDATE_DIV`, default 2500000: `vga_clk` cycles per half-period of `update_clk` (5 Hz at 25 MHz).
- `vga_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `btn_left`, `btn_up`, `btn_right`, `btn_down`  in  1 each  raw, asynchronous, active-high buttons.
- `update_clk`  out  1  registered divided clock; drives `game_logic.update_clk`.
- `direction`  out  [0:1]  current heading, encoded with `LEFT_DIR`/`TOP_DIR`/`RIGHT_DIR`/`DOWN_DIR` from define.vh.
- `queue_count`  out  2  number of pending turns (0..2).

## Operation
- **Sync:** each button passes through a 2-flop synchronizer.
- **Debounce (per button):**
  - The counter increments while the synced level ≠ the stable level, and clears when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with the levels still different, the stable level flips and the counter clears.
- **Press:** a one-cycle pulse on the stable 0→1 edge.
  - If several buttons press in the same cycle, priority is left > up > right > down; the others are dropped.
- **Reference direction:** the queue tail if the queue is non-empty, otherwise `direction`. It is evaluated on the pre-cycle state.
- **Accept rule:** a press is accepted only if it is ≠ the reference direction, is not its opposite (LEFT/RIGHT, TOP/DOWN), and the queue is not full after any same-cycle pop. Otherwise it is silently dropped.
- **Queue:** a 2-entry FIFO of 2-bit directions.
- **Divider:**
  - `div_cnt` counts 0..`UPDATE_DIV`-1 and wraps.
  - On the wrap, `update_clk` toggles.
  - Period is 2·`UPDATE_DIV` cycles; duty is 50 %.
- **Commit:** on the cycle `update_clk` toggles 1→0, if `queue_count`>0, `direction` ← head and the head is popped.
- **Push and pop in the same cycle:** both take effect.
  - Count 1 → stays 1; the new entry becomes the head.
  - Count 2 → stays 2; the push is accepted.
- **Button held:** a held button produces no repeat presses. A release plus a fresh press is required.

## Timing
- **Reset values (asynchronous, immediate):**
  - `update_clk`=0, `div_cnt`=0, `direction`=`RIGHT_DIR`, `queue_count`=0.
  - Synchronizers, stable levels and debounce counters are all 0.
- **Divider after reset release:** first `update_clk` rise after `UPDATE_DIV` cycles; first fall after 2·`UPDATE_DIV` cycles.
- **Press-to-queue latency:** 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge/push) cycles after the raw level settles.
- **Queue-to-direction latency:** `direction` changes only on the cycle after an `update_clk` 1→0 toggle. It is therefore constant for ≥`UPDATE_DIV` cycles before every `update_clk` rise.
- **Turns per update:** at most one turn is applied per `update_clk` period.
- **Reset mid-operation:** the queue is flushed, the divider phase restarts, and in-flight debounce is discarded.
- **Release after reset:** a button held through reset is seen as a new press once debounced, and is subject to the accept rule against `RIGHT_DIR`.

## Structure
- **define.vh (shared constants):**
  - Direction macros, unchanged.
  - New `OPPOSITE_DIR(d)` macro.
  - `DEBOUNCE_CYCLES_DEF` and `UPDATE_DIV_DEF`.
- **Sub-module:** `button_debouncer` (synchronizer + counter + stable level + press pulse, parameterised by `DEBOUNCE_CYCLES`), instantiated 4×.
- **Top level:** priority select, the turn FIFO, the divider and the commit logic stay in `snake_dir_input`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `UPDATE_DIV`=8.
- **Reset:** release reset → `direction`=RIGHT, `queue_count`=0, `update_clk` rises at cycle 8, falls at 16, rises at 24.
- **Bounce:**
  - `btn_up` high for 3 cycles then low → `queue_count` stays 0.
  - `btn_up` held → `queue_count`=1 after 7 cycles; `direction`=TOP the cycle after the next `update_clk` fall; `queue_count`=0.
- **Reverse/repeat rejection:** with `direction`=RIGHT, press left, then right → both dropped, `queue_count`=0, `direction` stays RIGHT.
- **Two queued turns:** from RIGHT, press up then left within one period → `queue_count`=2. First fall → `direction`=TOP; second fall → LEFT.
- **Full queue and priority:**
  - With 2 queued, press down → dropped.
  - With the queue empty and `direction`=RIGHT, up and down pressed in the same cycle → only TOP is queued.
  - A press landing on a commit cycle with count 2 is accepted, and count stays 2.
- **Reset mid-operation:** assert reset with `queue_count`=2 and `update_clk`=1 → immediately `queue_count`=0, `update_clk`=0, `direction`=RIGHT; the divider restarts from 0.

Source files
------------

// File: rtl/snake_dir_input_pkg.sv
// Shared constants for the snake direction input stage: heading encodings,
// default timing parameters and small helpers.
package snake_dir_input_pkg;

    localparam logic [1:0] LEFT_DIR  = 2'd0;
    localparam logic [1:0] TOP_DIR   = 2'd1;
    localparam logic [1:0] RIGHT_DIR = 2'd2;
    localparam logic [1:0] DOWN_DIR  = 2'd3;

    // 10 ms debounce and 5 Hz update at a 25 MHz pixel clock.
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int UPDATE_DIV_DEF      = 2500000;

    // Opposite pairs differ only in the upper bit (LEFT/RIGHT, TOP/DOWN).
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, stability counter, debounced level and
// a single-cycle pulse on each accepted 0->1 transition.
module button_debouncer
    import snake_dir_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] != r_stable) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                    // Only the rising flip is a press; releases stay silent.
                    r_press  <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/snake_dir_input.sv
// Direction input stage for game_logic: debounced buttons feed a 2-deep turn
// queue that is drained one turn per update_clk period on its falling edge.
module snake_dir_input
    import snake_dir_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int UPDATE_DIV      = UPDATE_DIV_DEF
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    output logic       update_clk,
    output logic [1:0] direction,
    output logic [1:0] queue_count
);

    localparam int DW = cnt_width(UPDATE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(UPDATE_DIV - 1);

    logic [3:0]    w_btn_raw;
    logic [3:0]    w_press;
    logic          w_press_valid;
    logic [1:0]    w_press_dir;
    logic          w_wrap;
    logic          w_fall;
    logic          w_pop;
    logic          w_push;
    logic          w_room;
    logic [1:0]    w_ref;

    logic [DW-1:0] r_div_cnt;
    logic          r_update_clk;
    logic [1:0]    r_dir;
    logic [1:0]    r_count;
    logic [1:0]    r_q0;
    logic [1:0]    r_q1;

    assign w_btn_raw = {btn_down, btn_right, btn_up, btn_left};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk  (vga_clk),
            .i_rst  (reset),
            .i_btn  (w_btn_raw[g]),
            .o_press(w_press[g])
        );
    end

    always_comb begin
        w_press_valid = |w_press;
        w_press_dir   = DOWN_DIR;
        if (w_press[0])      w_press_dir = LEFT_DIR;
        else if (w_press[1]) w_press_dir = TOP_DIR;
        else if (w_press[2]) w_press_dir = RIGHT_DIR;
    end

    assign w_wrap = (r_div_cnt == DIV_LAST);
    assign w_fall = w_wrap & r_update_clk;
    assign w_pop  = w_fall & (r_count != 2'd0);

    // New turns are judged against the last heading the snake will take.
    always_comb begin
        w_ref = r_dir;
        if (r_count == 2'd1)      w_ref = r_q0;
        else if (r_count == 2'd2) w_ref = r_q1;
    end

    assign w_room = (r_count != 2'd2) | w_pop;
    assign w_push = w_press_valid & w_room & (w_press_dir != w_ref)
                  & (w_press_dir != opposite_dir(w_ref));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_div_cnt    <= '0;
            r_update_clk <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt    <= '0;
            r_update_clk <= ~r_update_clk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_dir   <= RIGHT_DIR;
            r_count <= 2'd0;
            r_q0    <= RIGHT_DIR;
            r_q1    <= RIGHT_DIR;
        end else begin
            if (w_pop) r_dir <= r_q0;
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_q0 <= r_q1;
                        r_q1 <= w_press_dir;
                    end else begin
                        r_q0 <= w_press_dir;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) r_q0 <= w_press_dir;
                    else                 r_q1 <= w_press_dir;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q0    <= r_q1;
                    r_count <= r_count - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign update_clk  = r_update_clk;
    assign direction   = r_dir;
    assign queue_count = r_count;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with DEBOUNCE_CYCLES=4, UPDATE_DIV=8;
// cyc counts rising edges since the last reset release.
module tb_snake_dir_input;

    localparam int DEB = 4;
    localparam int DIV = 8;
    localparam logic [1:0] L = 2'd0;
    localparam logic [1:0] T = 2'd1;
    localparam logic [1:0] R = 2'd2;
    localparam logic [1:0] D = 2'd3;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_down = 1'b0;
    logic       update_clk;
    logic [1:0] direction;
    logic [1:0] queue_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 vga_clk = ~vga_clk;

    snake_dir_input #(
        .DEBOUNCE_CYCLES(DEB),
        .UPDATE_DIV     (DIV)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .update_clk (update_clk),
        .direction  (direction),
        .queue_count(queue_count)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        step(3);
        chk("rst_dir", direction, R);
        chk("rst_cnt", queue_count, 0);
        chk("rst_uclk", update_clk, 0);
        reset = 1'b0;
        cyc = 0;
        chk("rel_dir", direction, R);
        chk("rel_uclk", update_clk, 0);

        // Divider phase: rise at 8, fall at 16, rise at 24.
        goto(7);   chk("div7", update_clk, 0);
        goto(8);   chk("div8", update_clk, 1);
        goto(15);  chk("div15", update_clk, 1);
        goto(16);  chk("div16", update_clk, 0);
        goto(23);  chk("div23", update_clk, 0);
        goto(24);  chk("div24", update_clk, 1);

        // Reverse (LEFT) and repeat (RIGHT) from RIGHT are dropped.
        btn_left = 1'b1;
        goto(31);  chk("rev_left_cnt", queue_count, 0);
        btn_left = 1'b0;
        goto(37);  btn_right = 1'b1;
        goto(44);  chk("rep_right_cnt", queue_count, 0);
        btn_right = 1'b0;
        goto(50);  chk("rej_dir", direction, R);

        // A 3-cycle glitch never qualifies.
        btn_up = 1'b1;
        goto(53);  btn_up = 1'b0;
        goto(59);  chk("bounce_cnt", queue_count, 0);

        // Held UP: queued 7 cycles later, committed on the fall at 80.
        btn_up = 1'b1;
        goto(65);  chk("up_lat6", queue_count, 0);
        goto(66);  chk("up_lat7", queue_count, 1);
        goto(79);  chk("up_pre_dir", direction, R);
        goto(80);  chk("up_commit_dir", direction, T);
        chk("up_commit_cnt", queue_count, 0);
        goto(88);  chk("held_no_repeat", queue_count, 0);
        btn_up = 1'b0;

        // LEFT then DOWN from TOP; RIGHT into a full queue is dropped.
        goto(106); btn_left = 1'b1;
        goto(113); chk("two_q1", queue_count, 1);
        btn_left = 1'b0;
        btn_down = 1'b1;
        goto(114); btn_right = 1'b1;
        goto(120); chk("two_q2", queue_count, 2);
        btn_down = 1'b0;
        goto(121); chk("full_drop_cnt", queue_count, 2);
        btn_right = 1'b0;
        goto(127); chk("two_pre_dir", direction, T);
        goto(128); chk("two_fall1_dir", direction, L);
        chk("two_fall1_cnt", queue_count, 1);
        goto(143); chk("two_hold_dir", direction, L);
        goto(144); chk("two_fall2_dir", direction, D);
        chk("two_fall2_cnt", queue_count, 0);

        // LEFT and RIGHT in the same cycle: LEFT wins.
        btn_left = 1'b1;
        btn_right = 1'b1;
        goto(151); chk("prio_cnt", queue_count, 1);
        btn_left = 1'b0;
        btn_right = 1'b0;
        goto(160); chk("prio_dir", direction, L);
        chk("prio_cnt_after", queue_count, 0);

        // Push landing on a commit cycle with two queued.
        goto(161); btn_up = 1'b1;
        goto(162); btn_right = 1'b1;
        goto(168); chk("cp_q1", queue_count, 1);
        btn_up = 1'b0;
        goto(169); chk("cp_q2", queue_count, 2);
        btn_right = 1'b0;
        btn_down = 1'b1;
        goto(175); chk("cp_pre_dir", direction, L);
        goto(176); chk("cp_commit_dir", direction, T);
        chk("cp_commit_cnt", queue_count, 2);
        btn_down = 1'b0;
        goto(192); chk("cp_fall2_dir", direction, R);
        chk("cp_fall2_cnt", queue_count, 1);
        goto(208); chk("cp_fall3_dir", direction, D);
        chk("cp_fall3_cnt", queue_count, 0);

        // Reset mid-operation with two queued and update_clk high.
        goto(209); btn_left = 1'b1;
        goto(210); btn_up = 1'b1;
        goto(216); btn_left = 1'b0;
        goto(217); btn_up = 1'b0;
        chk("mid_pre_cnt", queue_count, 2);
        chk("mid_pre_uclk", update_clk, 1);
        goto(220);
        reset = 1'b1;
        #1;
        chk("mid_rst_cnt", queue_count, 0);
        chk("mid_rst_uclk", update_clk, 0);
        chk("mid_rst_dir", direction, R);
        step(2);
        reset = 1'b0;
        cyc = 0;
        goto(7);   chk("re_div7", update_clk, 0);
        goto(8);   chk("re_div8", update_clk, 1);
        goto(16);  chk("re_div16", update_clk, 0);
        chk("re_cnt", queue_count, 0);
        chk("re_dir", direction, R);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
